// File: rtl/lsu_mmio.sv
// Load/store unit: one request/acknowledge bus transaction per op, with lane
// steering, load extension and misaligned/illegal/timeout error reporting.
module lsu_mmio #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        op_we;
  logic [2:0]  op_funct3;
  logic [1:0]  op_ofs;
  logic [4:0]  op_rd;

  logic        funct_ok;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);

  // Decode the incoming op: legality, alignment, lane enables, store lanes.
  always_comb begin
    funct_ok   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b0000;
    wdata_next = 32'd0;
    case (req_funct3)
      3'b000, 3'b100: begin
        funct_ok   = (req_funct3 == 3'b000) || !req_we;
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        funct_ok   = (req_funct3 == 3'b001) || !req_we;
        misaligned = req_addr[0];
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        funct_ok   = 1'b1;
        misaligned = |req_addr[1:0];
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
      default: funct_ok = 1'b0;
    endcase
    if (!req_we) wdata_next = 32'd0;
  end

  always_comb begin
    shifted = mem_rdata >> {op_ofs, 3'b000};
    case (op_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      op_we      <= 1'b0;
      op_funct3  <= 3'd0;
      op_ofs     <= 2'd0;
      op_rd      <= 5'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_we     <= req_we;
            op_funct3 <= req_funct3;
            op_ofs    <= req_addr[1:0];
            op_rd     <= req_rd;
            cnt       <= 16'd0;
            if (!funct_ok || misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'd0;
              resp_rd    <= 5'd0;
            end else begin
              state     <= BUS;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack || cnt == TMO_LAST) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b1;
            resp_err   <= !mem_ack;
            resp_data  <= (mem_ack && !op_we) ? load_data : 32'd0;
            resp_rd    <= (mem_ack && !op_we) ? op_rd : 5'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= 32'd0;
          resp_rd    <= 5'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// Self-checking bench for lsu_mmio: directed scenarios plus randomized ops
// compared against a size/offset arithmetic reference model.
module tb_lsu_mmio;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  lsu_mmio #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // observed results of one op
  int          o_req_cycles, o_lat;
  logic        o_stable, o_pulse_ok, o_we, o_err;
  logic [31:0] o_addr, o_wdata, o_data;
  logic [3:0]  o_be;
  logic [4:0]  o_rd;

  // expected results of one op
  int          e_req_cycles, e_lat;
  logic        e_err;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;

  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int ack_delay);
    int size, k;
    bit sgn, legal;
    logic [31:0] v, mask;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: size = 4;
      3'b100: begin size = 1; legal = !we; end
      3'b101: begin size = 2; legal = !we; end
      default: legal = 0;
    endcase
    if (addr % size != 0) legal = 0;
    e_data = 32'd0; e_rd = 5'd0; e_be = 4'd0; e_wdata = 32'd0; e_addr = 32'd0;
    if (!legal) begin
      e_err = 1; e_req_cycles = 0; e_lat = 1;
      return;
    end
    k = int'(addr % 4);
    e_addr = addr - 32'(k);
    e_be = 4'(((1 << size) - 1) << k);
    if (we) e_wdata = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
                      (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    if (ack_delay + 1 > TMO) begin
      e_err = 1; e_req_cycles = TMO;
    end else begin
      e_err = 0; e_req_cycles = ack_delay + 1;
      if (!we) begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        v = (rdata >> (8 * k)) & mask;
        if (sgn && size < 4 && v[8 * size - 1]) v = v | ~mask;
        e_data = v;
        e_rd = rd;
      end
    end
    e_lat = e_req_cycles + 1;
  endtask

  // Drive one op from IDLE, ack after ack_delay wait cycles, record what happened.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int ack_delay,
                        input logic [31:0] rdata, input logic spur);
    o_req_cycles = 0; o_lat = -1; o_stable = 1; o_pulse_ok = 1;
    o_we = 0; o_err = 0; o_addr = 0; o_wdata = 0; o_data = 0; o_be = 0; o_rd = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    mem_ack = spur; mem_rdata = ~rdata;
    @(posedge clk); #1;
    req_valid = 0; mem_ack = 0;
    for (int cyc = 1; cyc <= 40 && o_lat < 0; cyc++) begin
      if (resp_valid) begin
        o_lat = cyc; o_data = resp_data; o_rd = resp_rd; o_err = resp_err;
        if (mem_req) o_pulse_ok = 0;
      end
      if (mem_req) begin
        if (o_req_cycles == 0) begin
          o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o_addr, o_be, o_wdata, o_we}) begin
          o_stable = 0;
        end
        o_req_cycles++;
        mem_ack = (o_req_cycles == ack_delay + 1);
        mem_rdata = mem_ack ? rdata : $urandom;
      end else begin
        mem_ack = 0;
      end
      if (o_lat < 0) begin @(posedge clk); #1; end
    end
    mem_ack = 0;
    @(posedge clk); #1;
    if (resp_valid || !req_ready) o_pulse_ok = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_data, resp_rd, resp_err}
        !== {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got ready=%b req=%b we=%b addr=%h be=%b wd=%h rv=%b rd=%h rrd=%0d err=%b, want ready=1 and all else 0",
               req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_data, resp_rd, resp_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    run_op(1'b0, 3'b000, 32'h1003, 32'd0, 5'd7, 0, 32'h80FF_1234, 1'b0);
    checks++;
    if ({o_addr, o_be, o_we, o_data, o_rd, o_err} !== {32'h1000, 4'b1000, 1'b0, 32'hFFFF_FF80, 5'd7, 1'b0}
        || o_lat != 2 || o_req_cycles != 1) begin
      errors++;
      $display("FAIL lb_0x1003: got addr=%h be=%b data=%h rd=%0d err=%b lat=%0d reqc=%0d, want 1000 1000 ffffff80 7 0 2 1",
               o_addr, o_be, o_data, o_rd, o_err, o_lat, o_req_cycles);
    end
    run_op(1'b0, 3'b101, 32'h2002, 32'd0, 5'd9, 3, 32'hBEEF_0000, 1'b0);
    checks++;
    if (o_data !== 32'h0000_BEEF || o_req_cycles != 4 || o_be !== 4'b1100 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL lhu_0x2002: got data=%h reqc=%0d be=%b err=%b, want 0000beef 4 1100 0", o_data, o_req_cycles, o_be, o_err);
    end
    run_op(1'b0, 3'b001, 32'h2002, 32'd0, 5'd9, 3, 32'hBEEF_0000, 1'b0);
    checks++;
    if (o_data !== 32'hFFFF_BEEF || o_rd !== 5'd9 || o_lat != 5) begin
      errors++;
      $display("FAIL lh_0x2002: got data=%h rd=%0d lat=%0d, want ffffbeef 9 5", o_data, o_rd, o_lat);
    end
  endtask

  task automatic test_stores();
    run_op(1'b1, 3'b000, 32'h3001, 32'h1234_56AB, 5'd3, 0, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if ({o_we, o_be, o_wdata, o_data, o_rd, o_err} !== {1'b1, 4'b0010, 32'hABAB_ABAB, 32'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL sb_0x3001: got we=%b be=%b wd=%h data=%h rd=%0d err=%b, want 1 0010 abababab 0 0 0",
               o_we, o_be, o_wdata, o_data, o_rd, o_err);
    end
    run_op(1'b1, 3'b001, 32'h3002, 32'h1234_56AB, 5'd3, 1, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if ({o_be, o_wdata, o_addr, o_rd} !== {4'b1100, 32'h56AB_56AB, 32'h3000, 5'd0}) begin
      errors++;
      $display("FAIL sh_0x3002: got be=%b wd=%h addr=%h rd=%0d, want 1100 56ab56ab 3000 0", o_be, o_wdata, o_addr, o_rd);
    end
  endtask

  task automatic test_errors();
    run_op(1'b0, 3'b010, 32'h4002, 32'd0, 5'd4, 0, 32'h1111_1111, 1'b0);
    checks++;
    if (o_req_cycles != 0 || o_lat != 1 || o_err !== 1'b1 || o_data !== 32'd0 || o_rd !== 5'd0) begin
      errors++;
      $display("FAIL lw_misaligned: got reqc=%0d lat=%0d err=%b data=%h rd=%0d, want 0 1 1 0 0",
               o_req_cycles, o_lat, o_err, o_data, o_rd);
    end
    run_op(1'b0, 3'b011, 32'h4000, 32'd0, 5'd4, 0, 32'h1111_1111, 1'b0);
    checks++;
    if (o_req_cycles != 0 || o_lat != 1 || o_err !== 1'b1 || o_data !== 32'd0) begin
      errors++;
      $display("FAIL funct3_011: got reqc=%0d lat=%0d err=%b data=%h, want 0 1 1 0", o_req_cycles, o_lat, o_err, o_data);
    end
    run_op(1'b1, 3'b100, 32'h4000, 32'd5, 5'd4, 0, 32'h1111_1111, 1'b0);
    checks++;
    if (o_req_cycles != 0 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL store_bu_illegal: got reqc=%0d err=%b, want 0 1", o_req_cycles, o_err);
    end
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'b010, 32'h5000, 32'd0, 5'd6, 1000, 32'h1234_5678, 1'b0);
    checks++;
    if (o_req_cycles != TMO || o_err !== 1'b1 || o_lat != TMO + 1 || o_data !== 32'd0 || o_rd !== 5'd0) begin
      errors++;
      $display("FAIL timeout_no_ack: got reqc=%0d err=%b lat=%0d data=%h rd=%0d, want %0d 1 %0d 0 0",
               o_req_cycles, o_err, o_lat, o_data, o_rd, TMO, TMO + 1);
    end
    run_op(1'b0, 3'b010, 32'h5000, 32'd0, 5'd6, TMO - 1, 32'h1234_5678, 1'b0);
    checks++;
    if (o_req_cycles != TMO || o_err !== 1'b0 || o_data !== 32'h1234_5678 || o_rd !== 5'd6) begin
      errors++;
      $display("FAIL ack_on_last_cycle: got reqc=%0d err=%b data=%h rd=%0d, want %0d 0 12345678 6",
               o_req_cycles, o_err, o_data, o_rd, TMO);
    end
  endtask

  task automatic test_random();
    logic we, spur;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdata;
    logic [4:0] rd;
    int dly;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
      rd = 5'($urandom); rdata = $urandom; dly = $urandom_range(0, 5); spur = 1'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = (f3[1] == 1'b1) ? 3'b010 : f3 & 3'b101;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'($urandom_range(0, 1) * 2);
      model_op(we, f3, addr, wd, rd, rdata, dly);
      run_op(we, f3, addr, wd, rd, dly, rdata, spur);
      checks++;
      if (o_lat != e_lat || o_req_cycles != e_req_cycles || o_err !== e_err || o_data !== e_data
          || o_rd !== e_rd || o_pulse_ok !== 1'b1) begin
        errors++;
        $display("FAIL rand_resp[%0d] we=%b f3=%b addr=%h dly=%0d: got lat=%0d reqc=%0d err=%b data=%h rd=%0d pulse=%b, want %0d %0d %b %h %0d 1",
                 i, we, f3, addr, dly, o_lat, o_req_cycles, o_err, o_data, o_rd, o_pulse_ok,
                 e_lat, e_req_cycles, e_err, e_data, e_rd);
      end
      if (e_req_cycles > 0) begin
        checks++;
        if ({o_addr, o_be, o_wdata, o_we, o_stable} !== {e_addr, e_be, e_wdata, we, 1'b1}) begin
          errors++;
          $display("FAIL rand_bus[%0d]: got addr=%h be=%b wd=%h we=%b stable=%b, want %h %b %h %b 1",
                   i, o_addr, o_be, o_wdata, o_we, o_stable, e_addr, e_be, e_wdata, we);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h6000; req_rd = 5'd1;
    @(posedge clk); #1;
    req_valid = 0; mem_ack = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bus: got mem_req=%b resp_valid=%b, want 0 0", mem_req, resp_valid);
    end
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_release: got %0d cycles with resp_valid/mem_req set or not ready, want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic        b_we[N];
    logic [2:0]  b_f3[N];
    logic [31:0] b_addr[N], b_wd[N], b_rdata[N];
    logic [4:0]  b_rd[N];
    logic [2:0]  ld_codes[5];
    int acc = 0, got = 0, last_acc = -10, gap_bad = 0, sz;
    logic prev_ready;
    ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < N; i++) begin
      b_we[i] = 1'($urandom);
      b_f3[i] = b_we[i] ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      sz = (b_f3[i][1:0] == 2'b00) ? 1 : (b_f3[i][1:0] == 2'b01) ? 2 : 4;
      b_addr[i] = $urandom & ~32'(sz - 1);
      b_wd[i] = $urandom; b_rdata[i] = $urandom; b_rd[i] = 5'($urandom);
    end
    req_valid = 1; req_we = b_we[0]; req_funct3 = b_f3[0]; req_addr = b_addr[0];
    req_wdata = b_wd[0]; req_rd = b_rd[0];
    prev_ready = req_ready;
    for (int cyc = 0; cyc < 200 && got < N; cyc++) begin
      @(posedge clk); #1;
      if (prev_ready && req_valid) begin
        if (cyc - last_acc < 3) gap_bad++;
        last_acc = cyc;
        acc++;
        if (acc < N) begin
          req_we = b_we[acc]; req_funct3 = b_f3[acc]; req_addr = b_addr[acc];
          req_wdata = b_wd[acc]; req_rd = b_rd[acc];
        end else begin
          req_valid = 0;
        end
      end
      mem_ack = mem_req;
      mem_rdata = (acc > 0) ? b_rdata[acc - 1] : 32'd0;
      if (resp_valid) begin
        model_op(b_we[got], b_f3[got], b_addr[got], b_wd[got], b_rd[got], b_rdata[got], 0);
        checks++;
        if (resp_data !== e_data || resp_rd !== e_rd || resp_err !== e_err) begin
          errors++;
          $display("FAIL b2b_resp[%0d]: got data=%h rd=%0d err=%b, want %h %0d %b",
                   got, resp_data, resp_rd, resp_err, e_data, e_rd, e_err);
        end
        got++;
      end
      prev_ready = req_ready;
    end
    req_valid = 0; mem_ack = 0;
    checks++;
    if (got != N || acc != N || gap_bad != 0) begin
      errors++;
      $display("FAIL b2b_count: got resp=%0d accepted=%0d close_accepts=%0d, want %0d %0d 0", got, acc, gap_bad, N, N);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
